// File: rtl/pipe_pkg.sv
// Types and constants shared by the fetch-side pipeline blocks.
// sext16to32 is also used by Execute for immediate branch offsets.
package pipe_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StIntSave,
        StIntJump
    } pc_state_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'd32;
    localparam logic [31:0] INT_VEC_DEF   = 32'd16;

    function automatic logic [31:0] sext16to32(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC and walks boot, sequential
// fetch, branches, stalls and the two-cycle interrupt entry sequence.
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] INT_VEC   = INT_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_addr,
    input  logic        int_req,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush,
    output logic [31:0] save_pc,
    output logic        save_valid,
    output logic        int_ack
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        int_pending_q, int_pending_d;
    logic        int_armed_q, int_armed_d;

    logic [31:0] branch_tgt;
    logic        int_capture;
    logic        int_want;

    assign branch_tgt = sext16to32(branch_addr);

    // A held int_req is captured once; it must drop before it can re-arm.
    assign int_capture = int_req && int_armed_q &&
                         (state_q == StBoot || state_q == StRun);
    assign int_want    = int_pending_q || int_capture;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        int_pending_d = int_pending_q;
        int_armed_d   = !int_req || (int_armed_q && !int_capture);
        pc            = pc_q;
        fetch_valid   = 1'b0;
        flush         = 1'b0;
        save_pc       = 32'd0;
        save_valid    = 1'b0;
        int_ack       = 1'b0;

        unique case (state_q)
            StBoot: begin
                pc_d          = RESET_VEC;
                int_pending_d = int_want;
                state_d       = StRun;
            end
            StRun: begin
                fetch_valid = !stall;
                if (branch) begin
                    pc_d          = branch_tgt;
                    flush         = 1'b1;
                    int_pending_d = int_want;
                end else if (int_want && !stall) begin
                    int_pending_d = 1'b1;
                    state_d       = StIntSave;
                end else if (stall) begin
                    int_pending_d = int_want;
                end else begin
                    pc_d          = pc_q + 32'd1;
                    int_pending_d = 1'b0;
                end
            end
            StIntSave: begin
                // A late branch redirects both the return address and the PC.
                save_valid    = 1'b1;
                save_pc       = branch ? branch_tgt : pc_q;
                pc_d          = branch ? branch_tgt : pc_q;
                int_pending_d = 1'b0;
                state_d       = StIntJump;
            end
            StIntJump: begin
                pc_d          = INT_VEC;
                flush         = 1'b1;
                int_ack       = 1'b1;
                int_pending_d = 1'b0;
                state_d       = StRun;
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        if (reset) begin
            state_d       = StBoot;
            pc_d          = RESET_VEC;
            int_pending_d = 1'b0;
            int_armed_d   = 1'b1;
            pc            = RESET_VEC;
            fetch_valid   = 1'b0;
            flush         = 1'b0;
            save_pc       = 32'd0;
            save_valid    = 1'b0;
            int_ack       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        pc_q          <= pc_d;
        int_pending_q <= int_pending_d;
        int_armed_q   <= int_armed_d;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios against fixed
// expected values, then randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'd32;
    localparam logic [31:0] IV = 32'd16;

    logic        clk = 1'b0;
    logic        reset, stall, branch, int_req;
    logic [15:0] branch_addr;
    logic [31:0] pc, save_pc;
    logic        fetch_valid, flush, save_valid, int_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .branch     (branch),
        .branch_addr(branch_addr),
        .int_req    (int_req),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .save_pc    (save_pc),
        .save_valid (save_valid),
        .int_ack    (int_ack)
    );

    always #5 clk = ~clk;

    // {pc, save_pc, fetch_valid, flush, save_valid, int_ack}
    wire [67:0] obs = {pc, save_pc, fetch_valid, flush, save_valid, int_ack};

    function automatic logic [67:0] pack(input logic [31:0] p, input logic [31:0] sp,
                                         input logic fv, input logic fl,
                                         input logic sv, input logic ack);
        return {p, sp, fv, fl, sv, ack};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [67:0] exp;
        reset = 1'b1; stall = 1'b0; branch = 1'b1; branch_addr = 16'h1234; int_req = 1'b1;
        exp = pack(RV, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset[%0d] got %h want %h", i, obs, exp);
            end
            tick();
        end
        branch = 1'b0; int_req = 1'b0;
    endtask

    task automatic test_boot_seq();
        logic [67:0] exp;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp = pack((i == 0) ? RV : RV + 32'(i - 1), 32'd0, i != 0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL boot_seq[%0d] got %h want %h", i, obs, exp);
            end
            tick();
        end
    endtask

    // Entered with pc = 36.
    task automatic test_stall();
        logic [67:0] exp;
        stall = 1'b1;
        exp = pack(32'd36, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got %h want %h", i, obs, exp);
            end
            tick();
        end
        branch = 1'b1; branch_addr = 16'h0080;
        exp = pack(32'd36, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL stall_branch got %h want %h", obs, exp);
        end
        tick();
        stall = 1'b0; branch = 1'b0;
        exp = pack(32'h80, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL stall_branch_tgt got %h want %h", obs, exp);
        end
        tick();
    endtask

    // Entered with pc = 0x81.
    task automatic test_branch();
        logic [15:0] addrs [3] = '{16'h0028, 16'hFFF0, 16'h0050};
        logic [31:0] pcs   [4] = '{32'h81, 32'd40, 32'hFFFF_FFF0, 32'h50};
        logic [67:0] exp;
        for (int i = 0; i < 4; i++) begin
            branch = (i < 3);
            if (i < 3) branch_addr = addrs[i];
            exp = pack(pcs[i], 32'd0, 1'b1, i < 3, 1'b0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL branch[%0d] got %h want %h", i, obs, exp);
            end
            tick();
        end
    endtask

    // Entered with pc = 0x51.
    task automatic test_interrupt();
        logic [67:0] exp [6];
        exp[0] = pack(32'h51, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp[1] = pack(32'd50, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[2] = pack(32'd50, 32'd50, 1'b0, 1'b0, 1'b1, 1'b0);
        exp[3] = pack(32'd50, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        exp[4] = pack(IV, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[5] = pack(IV + 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            branch = (i == 0); branch_addr = 16'd50;
            int_req = (i == 1);
            @(negedge clk);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL interrupt[%0d] got %h want %h", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_int_held();
        int acks = 0;
        int saves = 0;
        for (int i = 0; i < 16; i++) begin
            int_req = (i < 10);
            @(negedge clk);
            acks  += int'(int_ack);
            saves += int'(save_valid);
            tick();
        end
        n_cmp++;
        if (acks !== 1 || saves !== 1) begin
            n_fail++;
            $display("FAIL int_held acks=%0d saves=%0d want 1/1", acks, saves);
        end
    endtask

    task automatic test_int_stall();
        logic [67:0] exp [7];
        branch = 1'b1; branch_addr = 16'h0100;
        tick();
        branch = 1'b0;
        exp[0] = pack(32'h100, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp[1] = exp[0];
        exp[2] = exp[0];
        exp[3] = pack(32'h100, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[4] = pack(32'h100, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        exp[5] = pack(32'h100, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        exp[6] = pack(IV, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            stall   = (i < 3);
            int_req = (i == 0);
            @(negedge clk);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL int_stall[%0d] got %h want %h", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_in_int();
        logic [67:0] exp [7];
        branch = 1'b1; branch_addr = 16'h0200;
        tick();
        branch = 1'b0;
        exp[0] = pack(32'h200, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[1] = pack(RV, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp[2] = pack(RV, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i < 7; i++) exp[i] = pack(RV + 32'(i - 3), 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            int_req = (i == 0);
            reset   = (i == 1);
            @(negedge clk);
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_in_int[%0d] got %h want %h", i, obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
        logic [67:0] exp;
        branch = 1'b1; branch_addr = 16'hFFFF;
        tick();
        branch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = pack(pcs[i], 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL wrap[%0d] got %h want %h", i, obs, exp);
            end
            tick();
        end
    endtask

    // Model: m_boot marks the post-reset cycle, m_seq counts down the interrupt
    // entry (2 = saving, 1 = jumping, 0 = normal fetch).
    logic [31:0] m_pc;
    bit          m_boot, m_pend, m_armed;
    int          m_seq;

    task automatic test_random();
        logic [67:0] exp;
        logic [31:0] tgt;
        bit          newreq, want;
        for (int i = 0; i < 600; i++) begin
            reset       = (i == 0) || ($urandom_range(0, 49) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            branch      = ($urandom_range(0, 7) == 0);
            int_req     = ($urandom_range(0, 6) == 0);
            branch_addr = 16'($urandom);
            tgt         = 32'($signed(branch_addr));
            @(negedge clk);
            if (reset)            exp = pack(RV, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (m_boot)      exp = pack(m_pc, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (m_seq == 2)  exp = pack(m_pc, branch ? tgt : m_pc, 1'b0, 1'b0, 1'b1, 1'b0);
            else if (m_seq == 1)  exp = pack(m_pc, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            else                  exp = pack(m_pc, 32'd0, !stall, branch, 1'b0, 1'b0);
            if (i > 0) begin
                n_cmp++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d] got %h want %h", i, obs, exp);
                end
            end
            @(posedge clk);
            if (reset) begin
                m_pc = RV; m_boot = 1; m_seq = 0; m_pend = 0; m_armed = 1;
            end else begin
                newreq = int_req && m_armed && (m_seq == 0);
                m_armed = !int_req || (m_armed && !newreq);
                want = m_pend || newreq;
                if (m_boot) begin
                    m_boot = 0; m_pend = want; m_pc = RV;
                end else if (m_seq == 2) begin
                    if (branch) m_pc = tgt;
                    m_seq = 1; m_pend = 0;
                end else if (m_seq == 1) begin
                    m_pc = IV; m_seq = 0; m_pend = 0;
                end else if (branch) begin
                    m_pc = tgt; m_pend = want;
                end else if (want && !stall) begin
                    m_seq = 2;
                end else if (stall) begin
                    m_pend = want;
                end else begin
                    m_pc = m_pc + 32'd1;
                end
            end
            #1;
        end
        reset = 1'b0; stall = 1'b0; branch = 1'b0; int_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch = 1'b0; int_req = 1'b0; branch_addr = 16'd0;
        #1;
        test_reset();
        test_boot_seq();
        test_stall();
        test_branch();
        test_interrupt();
        test_int_held();
        test_int_stall();
        test_reset_in_int();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
